// File: rtl/bcd_timer_pkg.sv
// Shared types, active-low seven-segment patterns and the BCD borrow helper
// for the BCD countdown timer.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAUSED  = 2'd1,
        RUNNING = 2'd2,
        EXPIRED = 2'd3
    } timer_state_e;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // One link of the borrow chain: returns {borrow_out, digit_out}.
    function automatic logic [4:0] bcd_dec(input logic [3:0] digit, input logic borrow_in);
        logic [4:0] result;
        result = {1'b0, digit};
        if (borrow_in) begin
            if (digit == 4'd0) begin
                result = {1'b1, 4'd9};
            end else begin
                result = {1'b0, digit - 4'd1};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 blank.
module bcd_to_7seg
    import bcd_timer_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with tick prescaler and seven-segment outputs.
// Define AUTO_RELOAD_EN to reload the selected preset instead of expiring.
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int                        NUM_DIGITS = 2,
    parameter int                        TICK_DIV   = 50000000,
    parameter logic [4*NUM_DIGITS-1:0]   PRESET0    = 'h24,
    parameter logic [4*NUM_DIGITS-1:0]   PRESET1    = 'h30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      select,
    input  logic                      load,
    input  logic                      enable,
    output logic [4*NUM_DIGITS-1:0]   count,
    output logic [7*NUM_DIGITS-1:0]   seg,
    output logic                      running,
    output logic                      expired
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_preset_check
        if (PRESET0[4*i +: 4] > 4'd9 || PRESET1[4*i +: 4] > 4'd9) begin : g_bad_preset
            $error("bcd_countdown_timer: preset digit %0d is not a BCD digit", i);
        end
    end

    timer_state_e  state;
    logic [PW-1:0] pre;
    logic [W-1:0]  preset_sel;
    logic [W-1:0]  dec_val;
    logic          borrow;

    assign preset_sel = select ? PRESET1 : PRESET0;

    always_comb begin
        dec_val = '0;
        borrow  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            {borrow, dec_val[4*i +: 4]} = bcd_dec(count[4*i +: 4], borrow);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            pre     <= '0;
            running <= 1'b0;
            expired <= 1'b0;
        end else if (load) begin
            count   <= preset_sel;
            pre     <= '0;
            running <= 1'b0;
            if (preset_sel == '0) begin
                state   <= EXPIRED;
                expired <= 1'b1;
            end else begin
                state   <= PAUSED;
                expired <= 1'b0;
            end
        end else begin
            case (state)
                PAUSED: begin
                    if (enable) begin
                        state   <= RUNNING;
                        running <= 1'b1;
                    end
                end
                RUNNING: begin
                    expired <= 1'b0;
                    // Dropping enable wins over a coincident tick: no step.
                    if (!enable) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end else if (pre == PRE_MAX) begin
                        pre <= '0;
                        if (dec_val == '0) begin
`ifdef AUTO_RELOAD_EN
                            count   <= preset_sel;
                            expired <= 1'b1;
`else
                            count   <= '0;
                            state   <= EXPIRED;
                            running <= 1'b0;
                            expired <= 1'b1;
`endif
                        end else begin
                            count <= dec_val;
                        end
                    end else begin
                        pre <= pre + PW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_to_7seg u_dec (
            .bcd (count[4*i +: 4]),
            .seg (seg[7*i +: 7])
        );
    end

endmodule
